// File: rtl/tempo_step_gen_if.sv
// Control and status bundle between the sequencer controller and the tempo/step generator.
interface tempo_step_gen_if #(
  parameter int MAX_STEPS = 16,
  parameter int DIV_W     = 32,
  parameter int STEP_W    = $clog2(MAX_STEPS)
);
  logic              start;
  logic              pause;
  logic              stop;
  logic [DIV_W-1:0]  step_len;
  logic [DIV_W-1:0]  swing;
  logic [STEP_W-1:0] last_step;
  logic [STEP_W-1:0] step_num;
  logic              step_tick;
  logic              bar_tick;
  logic              beat_clk;
  logic              running;

  modport master (
    output start, pause, stop, step_len, swing, last_step,
    input  step_num, step_tick, bar_tick, beat_clk, running
  );

  modport slave (
    input  start, pause, stop, step_len, swing, last_step,
    output step_num, step_tick, bar_tick, beat_clk, running
  );
endinterface

// File: rtl/tempo_step_gen.sv
// Programmable step/tempo generator: per-step length with swing, variable pattern
// length and start/pause/stop transport; drives step address, strobes and beat LED.
module tempo_step_gen #(
  parameter int MAX_STEPS = 16,
  parameter int DIV_W     = 32,
  parameter int MIN_LEN   = 2,
  parameter int STEP_W    = $clog2(MAX_STEPS)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  tempo_step_gen_if.slave bus
);
  typedef enum logic [1:0] {STOPPED, RUNNING, PAUSED} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  len_q, len_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              step_tick_q, step_tick_d;
  logic              bar_tick_q, bar_tick_d;
  logic              beat_q, beat_d;
  logic              running_q;

  logic [DIV_W-1:0]  base, sw, len_even, len_odd;
  logic [DIV_W:0]    sum_even;
  logic [STEP_W-1:0] nxt;
  logic              advance, launch;

  // Candidate lengths for the step about to begin, from the live inputs.
  always_comb begin
    base     = (bus.step_len < DIV_W'(MIN_LEN)) ? DIV_W'(MIN_LEN) : bus.step_len;
    sw       = (bus.swing > (base >> 1)) ? (base >> 1) : bus.swing;
    sum_even = {1'b0, base} + {1'b0, sw};
    len_even = sum_even[DIV_W] ? '1 : sum_even[DIV_W-1:0];
    len_odd  = base - sw;
    nxt      = (step_q >= bus.last_step) ? '0 : step_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    step_d      = step_q;
    beat_d      = beat_q;
    step_tick_d = 1'b0;
    bar_tick_d  = 1'b0;
    advance     = 1'b0;
    launch      = 1'b0;

    if (bus.stop) begin
      state_d = STOPPED;
      cnt_d   = '0;
      step_d  = '0;
      beat_d  = 1'b0;
    end else if (bus.start) begin
      // start also shadows a simultaneous pause while already running
      case (state_q)
        STOPPED: launch  = 1'b1;
        default: advance = 1'b1;
      endcase
      state_d = RUNNING;
    end else if (bus.pause && state_q == RUNNING) begin
      state_d = PAUSED;
    end else if (state_q == RUNNING) begin
      advance = 1'b1;
    end

    if (launch) begin
      cnt_d       = '0;
      step_d      = '0;
      len_d       = len_even;
      step_tick_d = 1'b1;
      bar_tick_d  = 1'b1;
    end else if (advance) begin
      if (cnt_q == len_q - 1'b1) begin
        cnt_d       = '0;
        step_d      = nxt;
        len_d       = nxt[0] ? len_odd : len_even;
        step_tick_d = 1'b1;
        bar_tick_d  = (nxt == '0);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (launch || advance)
      beat_d = (cnt_d < (len_d >> 1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= STOPPED;
      cnt_q       <= '0;
      len_q       <= DIV_W'(MIN_LEN);
      step_q      <= '0;
      step_tick_q <= 1'b0;
      bar_tick_q  <= 1'b0;
      beat_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      step_q      <= step_d;
      step_tick_q <= step_tick_d;
      bar_tick_q  <= bar_tick_d;
      beat_q      <= beat_d;
      running_q   <= (state_d == RUNNING);
    end
  end

  assign bus.step_num  = step_q;
  assign bus.step_tick = step_tick_q;
  assign bus.bar_tick  = bar_tick_q;
  assign bus.beat_clk  = beat_q;
  assign bus.running   = running_q;
endmodule

// File: tb/tb_tempo_step_gen.sv
// Bench for tempo_step_gen: directed transport scenarios plus random traffic,
// every cycle compared against a cycle-level reference of the step rules.
module tb_tempo_step_gen;
  localparam int MAX_STEPS = 8;
  localparam int DIV_W     = 16;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  tempo_step_gen_if #(.MAX_STEPS(MAX_STEPS), .DIV_W(DIV_W)) bus ();

  tempo_step_gen #(.MAX_STEPS(MAX_STEPS), .DIV_W(DIV_W), .MIN_LEN(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference state: 0 stopped, 1 running, 2 paused
  int m_state = 0;
  int m_cnt   = 0;
  int m_len   = 2;
  int m_step  = 0;
  int m_tick  = 0;
  int m_bar   = 0;
  int m_beat  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int step_length(input int step);
    int base, sw, l;
    base = (int'(bus.step_len) < 2) ? 2 : int'(bus.step_len);
    sw   = (int'(bus.swing) > base / 2) ? base / 2 : int'(bus.swing);
    l    = (step % 2 == 0) ? base + sw : base - sw;
    if (l > 65535) l = 65535;
    return l;
  endfunction

  task automatic ref_move();
    m_tick = 0;
    m_bar  = 0;
    if (m_cnt == m_len - 1) begin
      m_step = (m_step >= int'(bus.last_step)) ? 0 : m_step + 1;
      m_cnt  = 0;
      m_len  = step_length(m_step);
      m_tick = 1;
      m_bar  = (m_step == 0);
    end else begin
      m_cnt++;
    end
    m_beat = (m_cnt < m_len / 2);
  endtask

  task automatic ref_update();
    if (reset || bus.stop) begin
      m_state = 0; m_cnt = 0; m_step = 0;
      m_tick = 0; m_bar = 0; m_beat = 0;
    end else if (bus.start && m_state == 0) begin
      m_state = 1; m_cnt = 0; m_step = 0;
      m_len = step_length(0);
      m_tick = 1; m_bar = 1; m_beat = 1;
    end else if (bus.start || (m_state == 1 && !bus.pause)) begin
      m_state = 1;
      ref_move();
    end else begin
      if (bus.pause && m_state == 1) m_state = 2;
      m_tick = 0; m_bar = 0;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      ref_update();
      @(posedge CLOCK_50);
      #1;
      check("step_num",  32'(bus.step_num),  32'(m_step));
      check("step_tick", 32'(bus.step_tick), 32'(m_tick));
      check("bar_tick",  32'(bus.bar_tick),  32'(m_bar));
      check("beat_clk",  32'(bus.beat_clk),  32'(m_beat));
      check("running",   32'(bus.running),   32'(m_state == 1));
      reset = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    end
  endtask

  // Advance until the reference sits at the given step/count, bounded.
  task automatic run_until(input int step, input int cnt);
    int guard = 0;
    while (!(m_step == step && m_cnt == cnt) && guard < 500) begin
      cyc(1);
      guard++;
    end
    check("reach_pos", 32'(guard < 500), 32'd1);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc(1);
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.step_len = 16'd10; bus.swing = '0; bus.last_step = 3'd7;
    reset = 1'b1;
    cyc(2);
    check("rst_step",    32'(bus.step_num),  32'd0);
    check("rst_running", 32'(bus.running),   32'd0);
    check("rst_beat",    32'(bus.beat_clk),  32'd0);

    // plain tempo, full bar and a bit
    do_start();
    check("start_bar", 32'(bus.bar_tick), 32'd1);
    cyc(90);

    // swing, then over-range swing
    bus.swing = 16'd3;  cyc(45);
    bus.swing = 16'd9;  cyc(45);
    bus.swing = '0;

    // length change mid-step, then minimum length
    run_until(1, 5);
    bus.step_len = 16'd4; cyc(20);
    bus.step_len = '0;    cyc(12);
    bus.step_len = 16'd10;

    // shrink pattern below current position, then one-step pattern
    run_until(6, 2);
    bus.last_step = 3'd3; cyc(30);
    bus.last_step = 3'd0; cyc(40);
    bus.last_step = 3'd7;

    // pause mid-step, hold, resume
    run_until(2, 4);
    bus.pause = 1'b1; cyc(1);
    cyc(19);
    do_start();
    cyc(7);
    check("resume_step", 32'(bus.step_num), 32'd3);

    // start+stop together, then restart and reset mid-step
    bus.start = 1'b1; bus.stop = 1'b1; cyc(1);
    check("stop_step", 32'(bus.step_num), 32'd0);
    cyc(5);
    do_start(); cyc(13);
    reset = 1'b1; cyc(1);
    check("rst_tick", 32'(bus.step_tick), 32'd0);
    cyc(3);

    // even-step length saturates rather than wrapping
    bus.step_len = 16'hFFF0; bus.swing = 16'h00FF;
    do_start(); cyc(300);
    bus.stop = 1'b1; cyc(1);

    // random transport and settings traffic
    bus.step_len = 16'd5; bus.swing = '0;
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 24) == 0);
      bus.pause = ($urandom_range(0, 29) == 0);
      bus.stop  = ($urandom_range(0, 79) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.step_len  = 16'($urandom_range(0, 12));
        bus.swing     = 16'($urandom_range(0, 8));
        bus.last_step = 3'($urandom_range(0, 7));
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
